// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a little-endian byte stream, assembles
// 32-bit words and writes them to consecutive word addresses from 0, holding
// the core stalled during the load and requesting a core restart at the end.
//
// Handshake: a byte moves when rx_valid & rx_ready are both 1 at a rising edge.
// rx_ready is a pure function of the FSM state (1 only while receiving). It
// never depends on rx_valid. The sender must hold rx_data stable while
// rx_valid is 1 and rx_ready is 0.

package riscv_pkg;
  localparam int ALEN            = 32;
  localparam int XLEN            = 32;
  localparam int RAM_MEMORY_SIZE = 1024;
endpackage

module imem_loader #(
  parameter int ALEN      = riscv_pkg::ALEN,
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int MEM_WORDS = riscv_pkg::RAM_MEMORY_SIZE,
  parameter int TIMEOUT   = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     len_words,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            we,
  output logic [ALEN-1:0] waddr,
  output logic [XLEN-1:0] wdata,
  output logic            cpu_stall,
  output logic            core_rst,
  output logic            done,
  output logic            err
);

  localparam int          CW      = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_LEN = 17'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  // state is the FSM state register; checkers can bind to it directly.
  state_t          state;
  state_t          state_nxt;
  logic [15:0]     len;
  logic [15:0]     word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     byte_buf;
  logic [CW-1:0]   idle_cnt;
  logic            xfer;
  logic            len_zero;
  logic            len_big;
  logic            last_word;
  logic            timeout_hit;

  // Decode helpers shared by the FSM and the datapath.
  always_comb begin
    xfer        = rx_valid && (state == RECV);
    len_zero    = (len_words == 16'd0);
    len_big     = ({1'b0, len_words} > MAX_LEN);
    last_word   = ((word_idx + 16'd1) == len);
    timeout_hit = (state == RECV) && !xfer && (idle_cnt == CW'(TIMEOUT - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    cpu_stall = 1'b1;
    done      = 1'b0;
    core_rst  = 1'b0;
    we        = 1'b0;
    case (state)
      IDLE: begin
        cpu_stall = 1'b0;
        if (start) begin
          if (len_zero)     state_nxt = DONE;
          else if (!len_big) state_nxt = RECV;
        end
      end
      RECV: begin
        rx_ready = 1'b1;
        if (xfer && (byte_idx == 2'd3)) state_nxt = WRITE;
        else if (timeout_hit)           state_nxt = IDLE;
      end
      WRITE: begin
        we        = 1'b1;
        state_nxt = last_word ? DONE : RECV;
      end
      DONE: begin
        done      = 1'b1;
        core_rst  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: counters, byte assembly, write address/data and the error flag.
  // waddr/wdata are loaded on the edge that enters WRITE and hold afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      byte_buf <= '0;
      idle_cnt <= '0;
      waddr    <= '0;
      wdata    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_big) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              len      <= len_words;
              word_idx <= '0;
              byte_idx <= '0;
              idle_cnt <= '0;
            end
          end
        end
        RECV: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            idle_cnt <= '0;
            case (byte_idx)
              2'd0: byte_buf[7:0]   <= rx_data;
              2'd1: byte_buf[15:8]  <= rx_data;
              2'd2: byte_buf[23:16] <= rx_data;
              default: begin
                wdata <= XLEN'({rx_data, byte_buf});
                waddr <= ALEN'({word_idx, 2'b00});
              end
            endcase
          end else if (timeout_hit) begin
            // Abort: the partial word is simply abandoned.
            err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          idle_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams with random gaps, checked
// against a word-level reference model of expected memory writes.
module tb_imem_loader;

  localparam int ALEN      = 32;
  localparam int XLEN      = 32;
  localparam int MEM_WORDS = 8;
  localparam int TIMEOUT   = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [15:0]     len_words;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic            we;
  logic [ALEN-1:0] waddr;
  logic [XLEN-1:0] wdata;
  logic            cpu_stall;
  logic            core_rst;
  logic            done;
  logic            err;

  int vectors;
  int miscompares;
  int exp_done;
  int done_seen;

  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];

  imem_loader #(
    .ALEN(ALEN), .XLEN(XLEN), .MEM_WORDS(MEM_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_stall(cpu_stall),
    .core_rst(core_rst), .done(done), .err(err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, wanted summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst && we) begin
      if (exp_q.size() == 0) check("unexpected_we", {waddr, wdata}, 64'hdead_0000_0000_0000);
      else check("write", {waddr, wdata}, exp_q.pop_front());
    end
    if (rst && done) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},        64'(we),        64'd0);
    check({tag, "_rx_ready"},  64'(rx_ready),  64'd0);
    check({tag, "_cpu_stall"}, 64'(cpu_stall), 64'd0);
    check({tag, "_core_rst"},  64'(core_rst),  64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_err"},       64'(err),       64'd0);
    check({tag, "_waddr"},     64'(waddr),     64'd0);
    check({tag, "_wdata"},     64'(wdata),     64'd0);
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    len_words = 16'(len);
    tick();
    start     = 1'b0;
  endtask

  // Send one byte; gap_mode 0 = none, 1 = exactly one idle cycle, 2 = random 0..3.
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gap;
    int waited;
    gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (!rx_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!rx_ready) check("rx_ready_wait", 64'(rx_ready), 64'd1);
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Reference word: little-endian combination of four stream bytes.
  function automatic logic [31:0] model_word(input int w);
    return 32'(stim[4*w]) + 32'(stim[4*w+1]) * 256 +
           32'(stim[4*w+2]) * 65536 + 32'(stim[4*w+3]) * 16777216;
  endfunction

  // Full load: bytes from stim (topped up randomly), expected writes pushed
  // to the scoreboard, latency and completion checked inline.
  task automatic run_load(input int len, input int gap_mode, input bit poke);
    while (stim.size() < 4 * len) stim.push_back(8'($urandom));
    for (int w = 0; w < len; w++) exp_q.push_back({32'(w * 4), model_word(w)});
    do_start(len);
    check("start_err_clear", 64'(err), 64'd0);
    check("start_stall", 64'(cpu_stall), 64'd1);
    for (int w = 0; w < len; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (poke && w == 0 && b == 1) begin
          start     = 1'b1;
          len_words = 16'($urandom_range(0, 40));
        end
        send_byte(stim[4*w+b], gap_mode);
        check("stall_held", 64'(cpu_stall), 64'd1);
      end
      check("we_latency", 64'(we), 64'd1);
      start = 1'b0;
    end
    tick();
    check("done_latency", 64'(done), 64'd1);
    check("core_rst_pulse", 64'(core_rst), 64'd1);
    exp_done++;
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("stall_dropped", 64'(cpu_stall), 64'd0);
    stim.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_done    = 0;
    done_seen   = 0;
    rst         = 1'b0;
    start       = 1'b0;
    len_words   = '0;
    rx_valid    = 1'b0;
    rx_data     = '0;

    // Reset state.
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Two-word directed load, back-to-back bytes.
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 1'b0);

    // One word with rx_valid toggling every cycle.
    run_load(1, 1, 1'b0);

    // Zero-length load completes immediately without writes.
    do_start(0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_core_rst", 64'(core_rst), 64'd1);
    check("len0_we", 64'(we), 64'd0);
    exp_done++;
    tick();
    check("len0_done_end", 64'(done), 64'd0);
    check("len0_stall_end", 64'(cpu_stall), 64'd0);

    // Oversize load is refused.
    do_start(MEM_WORDS + 1);
    check("big_err", 64'(err), 64'd1);
    check("big_stall", 64'(cpu_stall), 64'd0);
    check("big_rx_ready", 64'(rx_ready), 64'd0);
    repeat (3) tick();
    check("big_err_sticky", 64'(err), 64'd1);

    // Timeout after two bytes of a one-word load.
    do_start(1);
    check("to_err_clear", 64'(err), 64'd0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    repeat (TIMEOUT - 1) tick();
    check("to_still_recv", 64'(cpu_stall), 64'd1);
    check("to_no_err_yet", 64'(err), 64'd0);
    tick();
    check("to_err", 64'(err), 64'd1);
    check("to_idle", 64'(cpu_stall), 64'd0);
    check("to_rx_ready", 64'(rx_ready), 64'd0);
    repeat (3) tick();
    check("to_no_write", 64'(exp_q.size()), 64'd0);
    check("to_no_done", 64'(done_seen), 64'(exp_done));

    // Reset mid-load (six bytes of three words), with start and rx_valid also asserted.
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    exp_q.push_back({32'd0, model_word(0)});
    do_start(3);
    for (int b = 0; b < 6; b++) send_byte(stim[b], 2);
    stim.delete();
    rst       = 1'b0;
    start     = 1'b1;
    len_words = 16'd1;
    rx_valid  = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    tick();
    check("midrst_idle", 64'(cpu_stall), 64'd0);
    check("midrst_q_empty", 64'(exp_q.size()), 64'd0);
    run_load(1, 0, 1'b0);

    // start pulsed during RECV is ignored.
    run_load(3, 2, 1'b1);

    // Full-capacity load, then random loads.
    run_load(MEM_WORDS, 2, 1'b0);
    for (int n = 0; n < 6; n++) run_load(int'($urandom_range(1, MEM_WORDS)), 2, n[0]);

    repeat (5) tick();
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_done_count", 64'(done_seen), 64'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ALEN, riscv_pkg::ALEN, address width of waddr.
REQ-002 Parameter: XLEN, riscv_pkg::XLEN, data width of wdata (32).
REQ-003 Parameter: MEM_WORDS, riscv_pkg::RAM_MEMORY_SIZE, instruction memory capacity in words.
REQ-004 Parameter: TIMEOUT, 1024, max idle cycles between bytes in RECV before abort.
REQ-005 Port: clk  in  1  system clock, all state updates on rising edge.
REQ-006 Port: rst  in  1  reset; synchronous, active-low (rst=0 at a rising edge resets).
REQ-007 Port: start  in  1  load request, sampled only in IDLE.
REQ-008 Port: len_words  in  16  number of 32-bit words to load, sampled with start.
REQ-009 Port: rx_valid  in  1  byte stream valid.
REQ-010 Port: rx_data  in  8  byte stream data.
REQ-011 Port: rx_ready  out  1  loader accepts byte; transfer when rx_valid & rx_ready.
REQ-012 Port: we  out  1  instruction memory write strobe, one cycle per word.
REQ-013 Port: waddr  out  ALEN  byte address of word write (word-aligned).
REQ-014 Port: wdata  out  XLEN  assembled instruction word.
REQ-015 Port: cpu_stall  out  1  holds fetch/pipeline while loading.
REQ-016 Port: core_rst  out  1  one-cycle request to restart core at PC 0.
REQ-017 Port: done  out  1  one-cycle pulse, load completed.
REQ-018 Port: err  out  1  sticky error flag, cleared by reset or next accepted start.

Function
REQ-019 FSM states SHALL be IDLE, RECV, WRITE, DONE.
REQ-020 IDLE: start=1 & 0<len_words<=MEM_WORDS -> RECV, word_idx=0, byte_idx=0, err=0.
REQ-021 IDLE: start=1 & len_words=0 -> DONE, no writes, err=0.
REQ-022 IDLE: start=1 & len_words>MEM_WORDS -> stay IDLE, err=1, no writes.
REQ-023 start in any state other than IDLE SHALL be ignored.
REQ-024 rx_ready SHALL be 1 only in RECV; 0 in all other states.
REQ-025 Accepted bytes SHALL assemble little-endian: byte_idx 0 -> wdata[7:0] ... byte_idx 3 -> wdata[31:24].
REQ-026 Acceptance of byte_idx 3 SHALL move RECV -> WRITE next cycle, byte_idx wraps to 0.
REQ-027 WRITE: we=1 for exactly one cycle, waddr=word_idx<<2, wdata=assembled word; we=0 elsewhere.
REQ-028 After WRITE word_idx increments; if new word_idx==len_words -> DONE, else -> RECV.
REQ-029 Latency: 4th byte accepted at cycle N -> we=1 at N+1 -> done=1 at N+2 for last word.
REQ-030 DONE lasts one cycle: done=1, core_rst=1, then IDLE.
REQ-031 cpu_stall SHALL be 1 in RECV, WRITE, DONE; 0 in IDLE.
REQ-032 Idle counter SHALL reset on each accepted byte and on RECV entry; increments each RECV cycle without transfer.
REQ-033 Idle counter reaching TIMEOUT -> IDLE, err=1, partial word discarded, no we, no done, no core_rst.
REQ-034 waddr and wdata SHALL hold last value outside WRITE; word_idx never exceeds MEM_WORDS-1 at write.

Reset
REQ-035 rst=0 SHALL force IDLE; we, rx_ready, cpu_stall, core_rst, done, err =0; waddr=0; wdata=0; counters=0.
REQ-036 Reset mid-load SHALL discard partial word and remaining count; no further we until next start.
REQ-037 Reset SHALL take priority over start, rx transfers and timeout in the same cycle.

Verification
REQ-038 start, len_words=2, bytes 13 00 00 00 93 00 10 00 back-to-back -> we at waddr 0 wdata 0x00000013, we at waddr 4 wdata 0x00100093, done+core_rst one cycle, cpu_stall drops.
REQ-039 len_words=1 with rx_valid toggling 1/0 each cycle -> byte order preserved, single we, cpu_stall held throughout.
REQ-040 len_words=0 -> done=1 one cycle after start, no we; len_words=MEM_WORDS+1 -> err=1, state IDLE, cpu_stall=0.
REQ-041 len_words=1, 2 bytes sent then rx_valid=0 for TIMEOUT cycles -> err=1, IDLE, no we, no done.
REQ-042 rst=0 after 6 bytes of len_words=3 -> all outputs reset values; new start len_words=1 -> waddr 0 written.
REQ-043 start pulsed during RECV -> ignored; word_idx and len unchanged, load completes normally.
